// File: rtl/rd_stream_buf.sv
// rd_stream_buf: read-side output stage of the async FIFO (rclk domain).
// Converts the rempty/rinc pop interface plus synchronous-read memory data into
// a valid/ready stream through a 3-entry prefetch buffer. rinc depends only on
// registered state and rempty, never on m_ready.
//
// Ports:
//   rclk, rrst_n      read clock, asynchronous active-low reset
//   rempty            registered empty flag from the read-pointer block
//   rinc              pop request to the read-pointer block
//   rdata             memory read data, valid the cycle after a pop edge
//   m_valid, m_ready  output stream handshake
//   m_data            output word (buffer head, register driven)
//   buf_cnt           words currently held in the buffer (0..3)
module rd_stream_buf #(
  parameter int unsigned DWIDTH = 8
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              rempty,
  output logic              rinc,
  input  logic [DWIDTH-1:0] rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic [1:0]        buf_cnt
);

  logic [DWIDTH-1:0] buf_q [3];
  logic [1:0]        head_q;
  logic [1:0]        tail_q;
  logic [1:0]        cnt_q;
  logic              infl_q;

  logic              push;
  logic              pop;
  logic [2:0]        occ;

  // Index increment with wrap 2 -> 0; value 3 is never produced.
  function automatic logic [1:0] idx_inc(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  always_comb begin
    // Buffered plus in-flight words; must never exceed the 3 slots.
    occ     = {1'b0, cnt_q} + {2'b00, infl_q};
    rinc    = ~rempty & (occ < 3'd3);
    m_valid = (cnt_q != 2'd0);
    pop     = m_valid & m_ready;
    push    = infl_q;
    buf_cnt = cnt_q;
    case (head_q)
      2'd1:    m_data = buf_q[1];
      2'd2:    m_data = buf_q[2];
      default: m_data = buf_q[0];
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      head_q <= 2'd0;
      tail_q <= 2'd0;
      cnt_q  <= 2'd0;
      infl_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      // rdata carries a popped word exactly one cycle after a rinc edge.
      infl_q <= rinc;
      if (push) begin
        for (int i = 0; i < 3; i++) begin
          if (tail_q == 2'(i)) begin
            buf_q[i] <= rdata;
          end
        end
        tail_q <= idx_inc(tail_q);
      end
      if (pop) begin
        head_q <= idx_inc(head_q);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
